// File: rtl/display_scan_controller.sv
// display_scan_controller
// Time-multiplexed scan sequencer for an N-digit common-anode 7-segment display.
// Alternates between an all-off BLANK gap and a SHOW slot per digit, advancing the
// digit index on each refresh tick. Anodes, segments, DP and the frame pulse are
// all registered and take the value for the state being entered on the same edge.
//
// Handshake: there is no valid/ready pair here. iTick is a one-cycle strobe that is
// consumed only when it coincides with an enabled cycle in SHOW; elsewhere it is dropped.
module display_scan_controller #(
    parameter int N_DIGITS     = 4,
    parameter int BLANK_CYCLES = 8,
    parameter int W_IDX        = 2
) (
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic                  iCE,
    input  logic                  iTick,
    input  logic [4*N_DIGITS-1:0] ivDigits,
    input  logic [N_DIGITS-1:0]   ivDP,
    input  logic [N_DIGITS-1:0]   ivEnable,
    input  logic                  iLeadBlank,
    output logic [N_DIGITS-1:0]   ovAnode,
    output logic [6:0]            ovSeg,
    output logic                  oDP,
    output logic [W_IDX-1:0]      ovDigitIdx,
    output logic                  oFrame,
    output logic [1:0]            ovDbgState
);

    localparam int W_CNT = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(BLANK_CYCLES - 1);
    localparam logic [W_IDX-1:0] IDX_LAST = W_IDX'(N_DIGITS - 1);

    // Two legal encodings; the other two recover to BLANK.
    localparam logic [1:0] ST_BLANK = 2'b00;
    localparam logic [1:0] ST_SHOW  = 2'b01;

    logic [1:0]          state_q, state_d;
    logic [W_IDX-1:0]    idx_q, idx_d;
    logic [W_CNT-1:0]    cnt_q, cnt_d;
    logic [N_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic                frame_q, frame_d;

    logic [3:0]          digit_w [N_DIGITS];
    logic [N_DIGITS-1:0] lead_zero_w;
    logic                lit_w;
    logic                acc_zero;

    // Hex nibble to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Unpack digits and find, for each slot, whether it and every higher digit are zero.
    always_comb begin
        lead_zero_w = '0;
        acc_zero    = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            digit_w[i] = ivDigits[4*i +: 4];
        end
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            acc_zero       = acc_zero & (digit_w[i] == 4'h0);
            lead_zero_w[i] = acc_zero;
        end
    end

    // State register: synchronous reset wins over the clock enable.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q <= ST_BLANK;
            idx_q   <= '0;
            cnt_q   <= '0;
            anode_q <= '1;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
        end else if (iCE) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
        end
    end

    // Next state: fixed-length BLANK gap, SHOW held until a tick advances the index.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + W_CNT'(1);
                end
            end
            ST_SHOW: begin
                if (iTick) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + W_IDX'(1);
                end
            end
            default: begin
                state_d = ST_BLANK;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs for the state being entered; an unlit slot stays dark but keeps its time.
    always_comb begin
        anode_d = '1;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        lit_w   = ivEnable[idx_d] &&
                  !(iLeadBlank && (idx_d != '0) && lead_zero_w[idx_d]);
        frame_d = (state_q == ST_SHOW) && iTick && (idx_q == IDX_LAST);
        if ((state_d == ST_SHOW) && lit_w) begin
            anode_d[idx_d] = 1'b0;
            seg_d          = hex_to_seg(digit_w[idx_d]);
            dp_d           = ~ivDP[idx_d];
        end
    end

    assign ovAnode    = anode_q;
    assign ovSeg      = seg_q;
    assign oDP        = dp_q;
    assign ovDigitIdx = idx_q;
    assign oFrame     = frame_q;
    assign ovDbgState = state_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with N_DIGITS=4, BLANK_CYCLES=2.
// Inputs are driven and outputs sampled on the falling edge.
module tb_display_scan_controller;

  logic        iClk;
  logic        iReset;
  logic        iCE;
  logic        iTick;
  logic [15:0] ivDigits;
  logic [3:0]  ivDP;
  logic [3:0]  ivEnable;
  logic        iLeadBlank;
  logic [3:0]  ovAnode;
  logic [6:0]  ovSeg;
  logic        oDP;
  logic [1:0]  ovDigitIdx;
  logic        oFrame;
  logic [1:0]  ovDbgState;

  int total;
  int bad;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        lead;
    logic [15:0] exp_an;   // slot i at [4i+:4]
    logic [27:0] exp_seg;  // slot i at [7i+:7]
    logic [3:0]  exp_dp;   // slot i at [i]
  } vec_t;

  vec_t tbl[8];

  display_scan_controller #(
    .N_DIGITS(4),
    .BLANK_CYCLES(2),
    .W_IDX(2)
  ) dut (
    .iClk(iClk),
    .iReset(iReset),
    .iCE(iCE),
    .iTick(iTick),
    .ivDigits(ivDigits),
    .ivDP(ivDP),
    .ivEnable(ivEnable),
    .iLeadBlank(iLeadBlank),
    .ovAnode(ovAnode),
    .ovSeg(ovSeg),
    .oDP(oDP),
    .ovDigitIdx(ovDigitIdx),
    .oFrame(oFrame),
    .ovDbgState(ovDbgState)
  );

  // clock / reset block
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic clk(input int n);
    repeat (n) @(negedge iClk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_show(input logic [1:0] idx, input logic [3:0] an,
                            input logic [6:0] seg, input logic dp);
    check("show_anode", ovAnode, an);
    check("show_seg", ovSeg, seg);
    check("show_dp", oDP, dp);
    check("show_idx", ovDigitIdx, idx);
    check("show_frame", oFrame, 0);
    check("show_state", ovDbgState, 2'b01);
  endtask

  task automatic check_blank(input logic [1:0] idx, input logic frame);
    check("blank_anode", ovAnode, 4'hF);
    check("blank_seg", ovSeg, 7'h7F);
    check("blank_dp", oDP, 1'b1);
    check("blank_idx", ovDigitIdx, idx);
    check("blank_frame", oFrame, frame);
    check("blank_state", ovDbgState, 2'b00);
  endtask

  // driver tasks
  task automatic do_reset();
    iReset = 1'b1;
    iTick  = 1'b0;
    clk(2);
    iReset = 1'b0;
    check_blank(2'd0, 1'b0);
  endtask

  task automatic pulse_tick();
    iTick = 1'b1;
    clk(1);
    iTick = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    iReset     = 1'b1;
    iCE        = 1'b1;
    iTick      = 1'b0;
    ivDigits   = 16'h1234;
    ivDP       = 4'h0;
    ivEnable   = 4'hF;
    iLeadBlank = 1'b0;

    tbl[0] = '{16'h1234, 4'h0, 4'hF, 1'b0, 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
    tbl[1] = '{16'h0050, 4'h0, 4'hF, 1'b1, 16'hFFDE, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF};
    tbl[2] = '{16'h0050, 4'h0, 4'hF, 1'b0, 16'h7BDE, {7'h40, 7'h40, 7'h12, 7'h40}, 4'hF};
    tbl[3] = '{16'h1234, 4'h0, 4'b0101, 1'b0, 16'hFBFE, {7'h7F, 7'h24, 7'h7F, 7'h19}, 4'hF};
    tbl[4] = '{16'hABCD, 4'b0010, 4'hF, 1'b0, 16'h7BDE, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1101};
    tbl[5] = '{16'h89EF, 4'hF, 4'hF, 1'b1, 16'h7BDE, {7'h00, 7'h10, 7'h06, 7'h0E}, 4'b0000};
    tbl[6] = '{16'h0000, 4'hF, 4'hF, 1'b1, 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110};
    tbl[7] = '{16'h0607, 4'b0001, 4'b1110, 1'b1, 16'hFBDF, {7'h7F, 7'h02, 7'h40, 7'h7F}, 4'hF};

    // Table: one full frame per vector, each slot checked along with its blank gap.
    for (int v = 0; v < 8; v++) begin
      ivDigits   = tbl[v].digits;
      ivDP       = tbl[v].dp;
      ivEnable   = tbl[v].en;
      iLeadBlank = tbl[v].lead;
      do_reset();
      clk(1);
      check_blank(2'd0, 1'b0);
      clk(1);
      for (int s = 0; s < 4; s++) begin
        check_show(2'(s), tbl[v].exp_an[4*s +: 4], tbl[v].exp_seg[7*s +: 7], tbl[v].exp_dp[s]);
        clk(3);
        check_show(2'(s), tbl[v].exp_an[4*s +: 4], tbl[v].exp_seg[7*s +: 7], tbl[v].exp_dp[s]);
        pulse_tick();
        check_blank(2'((s + 1) % 4), (s == 3));
        clk(1);
        check_blank(2'((s + 1) % 4), 1'b0);
        clk(1);
      end
      check_show(2'd0, tbl[v].exp_an[3:0], tbl[v].exp_seg[6:0], tbl[v].exp_dp[0]);
    end

    // Input change during SHOW shows up one cycle later.
    ivDigits = 16'h1234; ivDP = 4'h0; ivEnable = 4'hF; iLeadBlank = 1'b0;
    do_reset();
    clk(2);
    check_show(2'd0, 4'hE, 7'h19, 1'b1);
    ivDigits = 16'h1235;
    ivDP     = 4'h1;
    check_show(2'd0, 4'hE, 7'h19, 1'b1);
    clk(1);
    check_show(2'd0, 4'hE, 7'h12, 1'b0);
    ivEnable = 4'hE;
    clk(1);
    check_show(2'd0, 4'hF, 7'h7F, 1'b1);
    ivDigits = 16'h1234; ivDP = 4'h0; ivEnable = 4'hF;

    // Clock-enable freeze in SHOW, ticks ignored; then freeze in the middle of BLANK.
    do_reset();
    clk(2);
    pulse_tick();
    clk(2);
    check_show(2'd1, 4'hD, 7'h30, 1'b1);
    iCE = 1'b0;
    for (int k = 0; k < 20; k++) begin
      iTick = (k == 3 || k == 9 || k == 15);
      clk(1);
      check_show(2'd1, 4'hD, 7'h30, 1'b1);
    end
    iTick = 1'b0;
    iCE   = 1'b1;
    clk(1);
    check_show(2'd1, 4'hD, 7'h30, 1'b1);
    pulse_tick();
    check_blank(2'd2, 1'b0);
    iCE = 1'b0;
    clk(5);
    check_blank(2'd2, 1'b0);
    iCE = 1'b1;
    clk(1);
    check_blank(2'd2, 1'b0);
    clk(1);
    check_show(2'd2, 4'hB, 7'h24, 1'b1);

    // Reset in SHOW at idx 2, together with a tick.
    iReset = 1'b1;
    iTick  = 1'b1;
    clk(1);
    iReset = 1'b0;
    iTick  = 1'b0;
    check_blank(2'd0, 1'b0);

    // Tick on the last BLANK cycle is not consumed.
    clk(2);
    check_show(2'd0, 4'hE, 7'h19, 1'b1);
    pulse_tick();
    check_blank(2'd1, 1'b0);
    clk(1);
    check_blank(2'd1, 1'b0);
    pulse_tick();
    check_show(2'd1, 4'hD, 7'h30, 1'b1);
    clk(3);
    check_show(2'd1, 4'hD, 7'h30, 1'b1);
    pulse_tick();
    check_blank(2'd2, 1'b0);

    // Wrap from idx 3 in the middle of a run produces exactly one frame pulse.
    clk(2);
    pulse_tick();
    clk(2);
    check_show(2'd3, 4'h7, 7'h79, 1'b1);
    pulse_tick();
    check_blank(2'd0, 1'b1);
    clk(1);
    check_blank(2'd0, 1'b0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
